// File: rtl/joybus_tx_engine.sv
// Joybus controller-side response transmitter: serialises an MSB-first byte payload
// into L/H level encoding, appends the controller stop bit and hands the line back.
module joybus_tx_engine #(
  parameter int LEVEL_WIDTH = 2,
  parameter int MAX_BYTES   = 4,
  parameter int LEN_W       = 3
) (
  input  logic                   sample_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       tx_len,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  output logic                   drive_low,
  output logic                   busy,
  output logic                   done,
  output logic                   rx_handoff,
  output logic                   len_err
);

  localparam int DW    = 8 * MAX_BYTES;
  localparam int LVL_W = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
  localparam int BIT_W = $clog2(DW + 1);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVEL_WIDTH - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BYTES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_STOP   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [1:0]       phase_q, phase_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [BIT_W-1:0] nbits_q, nbits_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic             drive_low_q, drive_low_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rx_handoff_q, rx_handoff_d;
  logic             len_err_q, len_err_d;

  // Phase 0 is always L, phase 3 always H; the middle two carry the data bit.
  function automatic logic data_level(input logic b, input logic [1:0] ph);
    case (ph)
      2'd0:       data_level = 1'b1;
      2'd1, 2'd2: data_level = ~b;
      default:    data_level = 1'b0;
    endcase
  endfunction

  function automatic logic stop_level(input logic [1:0] ph);
    stop_level = ~ph[1];
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d      = state_q;
    lvl_d        = lvl_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    nbits_d      = nbits_q;
    shift_d      = shift_q;
    drive_low_d  = drive_low_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rx_handoff_d = 1'b0;
    len_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        drive_low_d = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          if (tx_len > LEN_MAX) begin
            len_err_d = 1'b1;
          end else begin
            shift_d     = tx_data;
            nbits_d     = BIT_W'({tx_len, 3'b000});
            lvl_d       = {LVL_W{1'b0}};
            phase_d     = 2'd0;
            bit_d       = {BIT_W{1'b0}};
            busy_d      = 1'b1;
            drive_low_d = 1'b1;
            state_d     = (tx_len == {LEN_W{1'b0}}) ? S_STOP : S_SEND;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (lvl_q == LVL_LAST) begin
          lvl_d = {LVL_W{1'b0}};
          if (phase_q == 2'd3) begin
            phase_d     = 2'd0;
            drive_low_d = 1'b1;
            if (bit_q == nbits_q - BIT_W'(1)) begin
              state_d = S_STOP;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = {shift_q[DW-2:0], 1'b0};
            end
          end else begin
            phase_d     = phase_q + 2'd1;
            drive_low_d = data_level(shift_q[DW-1], phase_q + 2'd1);
          end
        end else begin
          lvl_d = lvl_q + LVL_W'(1);
        end
      end
      S_STOP: begin
        if (lvl_q == LVL_LAST) begin
          lvl_d = {LVL_W{1'b0}};
          if (phase_q == 2'd3) begin
            state_d      = S_FINISH;
            phase_d      = 2'd0;
            drive_low_d  = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            rx_handoff_d = 1'b1;
          end else begin
            phase_d     = phase_q + 2'd1;
            drive_low_d = stop_level(phase_q + 2'd1);
          end
        end else begin
          lvl_d = lvl_q + LVL_W'(1);
        end
      end
      S_FINISH: begin
        state_d     = S_IDLE;
        drive_low_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        drive_low_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State register; a low reset releases the line at once, even mid-frame.
  always_ff @(posedge sample_clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lvl_q        <= {LVL_W{1'b0}};
      phase_q      <= 2'd0;
      bit_q        <= {BIT_W{1'b0}};
      nbits_q      <= {BIT_W{1'b0}};
      shift_q      <= {DW{1'b0}};
      drive_low_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_handoff_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lvl_q        <= lvl_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      nbits_q      <= nbits_d;
      shift_q      <= shift_d;
      drive_low_q  <= drive_low_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rx_handoff_q <= rx_handoff_d;
      len_err_q    <= len_err_d;
    end
  end

  assign drive_low  = drive_low_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rx_handoff = rx_handoff_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_joybus_tx_engine.sv
// Bench for joybus_tx_engine: directed frames plus random payloads, each compared
// cycle by cycle against a level trace expanded from the Joybus encoding rules.
module tb_joybus_tx_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [2:0]  len1, len2;
  logic [31:0] data1, data2;
  logic        dl1, busy1, done1, rx1, le1;
  logic        dl2, busy2, done2, rx2, le2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  joybus_tx_engine #(.LEVEL_WIDTH(2), .MAX_BYTES(4), .LEN_W(3)) dut1 (
    .sample_clk(clk), .reset(reset), .start(start1), .tx_len(len1), .tx_data(data1),
    .drive_low(dl1), .busy(busy1), .done(done1), .rx_handoff(rx1), .len_err(le1)
  );

  joybus_tx_engine #(.LEVEL_WIDTH(4), .MAX_BYTES(4), .LEN_W(3)) dut2 (
    .sample_clk(clk), .reset(reset), .start(start2), .tx_len(len2), .tx_data(data2),
    .drive_low(dl2), .busy(busy2), .done(done2), .rx_handoff(rx2), .len_err(le2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic o_dl(input int w);   return (w == 2) ? dl2   : dl1;   endfunction
  function automatic logic o_busy(input int w); return (w == 2) ? busy2 : busy1; endfunction
  function automatic logic o_done(input int w); return (w == 2) ? done2 : done1; endfunction
  function automatic logic o_rx(input int w);   return (w == 2) ? rx2   : rx1;   endfunction
  function automatic logic o_le(input int w);   return (w == 2) ? le2   : le1;   endfunction

  task automatic set_in(input int w, input logic s, input logic [2:0] len, input logic [31:0] data);
    if (w == 2) begin
      start2 = s; len2 = len; data2 = data;
    end else begin
      start1 = s; len1 = len; data1 = data;
    end
  endtask

  // Request a frame, then scramble the inputs so later changes must not matter.
  task automatic start_frame(input int w, input int len, input logic [31:0] data);
    set_in(w, 1'b1, 3'(len), data);
    tick();
    set_in(w, 1'b0, 3'($urandom_range(7, 0)), $urandom);
  endtask

  // Called just after the accepting edge; fin_start raises start during FINISH.
  task automatic expect_frame(input int w, input int len, input logic [31:0] data, input int lw,
                              input int restart_at, input int abort_at, input bit fin_start);
    logic exp_q[$];
    int   busy_cnt = 0;
    for (int i = 0; i < 8 * len; i++) begin
      for (int p = 0; p < 4; p++) begin
        for (int r = 0; r < lw; r++) exp_q.push_back((p == 0) ? 1'b1 : (p == 3) ? 1'b0 : ~data[31 - i]);
      end
    end
    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < lw; r++) exp_q.push_back(p < 2);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (abort_at > 0 && k == abort_at) begin
        reset = 1'b0;
        tick();
        check("abort_drive", o_dl(w), 1'b0);
        check("abort_busy", o_busy(w), 1'b0);
        check("abort_done", o_done(w), 1'b0);
        reset = 1'b1;
        for (int j = 0; j < 6; j++) begin
          tick();
          check("post_abort_idle", {o_dl(w), o_busy(w), o_done(w), o_rx(w)}, 4'b0000);
        end
        return;
      end
      check("drive_level", o_dl(w), exp_q[k]);
      check("busy_in_frame", o_busy(w), 1'b1);
      check("no_done_in_frame", o_done(w), 1'b0);
      check("no_len_err_in_frame", o_le(w), 1'b0);
      if (o_busy(w)) busy_cnt++;
      if (k == restart_at) set_in(w, 1'b1, 3'($urandom_range(7, 0)), $urandom);
      else set_in(w, 1'b0, 3'($urandom_range(7, 0)), $urandom);
      tick();
    end
    check("busy_cycles", busy_cnt, (32 * len + 4) * lw);
    check("finish_done", o_done(w), 1'b1);
    check("finish_rx_handoff", o_rx(w), 1'b1);
    check("finish_busy", o_busy(w), 1'b0);
    check("finish_drive", o_dl(w), 1'b0);
    if (fin_start) set_in(w, 1'b1, 3'd0, $urandom);
    tick();
    check("done_single_cycle", o_done(w), 1'b0);
    check("rx_single_cycle", o_rx(w), 1'b0);
    check("idle_after_finish", o_busy(w), 1'b0);
    if (fin_start) begin
      tick();
      set_in(w, 1'b0, 3'd0, $urandom);
      check("accept_first_idle", o_busy(w), 1'b1);
    end
  endtask

  initial begin
    int w, len, lw;
    logic [31:0] d;
    reset = 1'b0;
    set_in(1, 1'b0, 3'd0, 32'h0);
    set_in(2, 1'b0, 3'd0, 32'h0);
    repeat (3) tick();
    check("reset_dut1", {dl1, busy1, done1, rx1, le1}, 5'b00000);
    check("reset_dut2", {dl2, busy2, done2, rx2, le2}, 5'b00000);
    reset = 1'b1;
    tick();

    start_frame(1, 3, 32'h0500_0000);
    expect_frame(1, 3, 32'h0500_0000, 2, -1, 0, 1'b0);
    start_frame(1, 4, 32'h0000_0000);
    expect_frame(1, 4, 32'h0000_0000, 2, -1, 0, 1'b0);
    start_frame(1, 0, 32'hFFFF_FFFF);
    expect_frame(1, 0, 32'hFFFF_FFFF, 2, -1, 0, 1'b1);
    expect_frame(1, 0, 32'h0, 2, -1, 0, 1'b0);

    set_in(1, 1'b1, 3'd5, 32'hDEAD_BEEF);
    tick();
    set_in(1, 1'b0, 3'd0, 32'h0);
    check("len_err_pulse", le1, 1'b1);
    check("len_err_line", {dl1, busy1, done1}, 3'b000);
    tick();
    check("len_err_single", le1, 1'b0);
    check("len_err_stays_idle", {dl1, busy1, done1}, 3'b000);

    d = $urandom;
    start_frame(1, 2, d);
    expect_frame(1, 2, d, 2, 17, 0, 1'b0);
    d = $urandom;
    start_frame(1, 4, d);
    expect_frame(1, 4, d, 2, 9, 40, 1'b0);
    start_frame(1, 1, 32'h8000_0000);
    expect_frame(1, 1, 32'h8000_0000, 2, -1, 0, 1'b0);
    start_frame(2, 1, 32'hA500_0000);
    expect_frame(2, 1, 32'hA500_0000, 4, -1, 0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      w   = $urandom_range(2, 1);
      lw  = (w == 2) ? 4 : 2;
      len = $urandom_range(4, 0);
      d   = $urandom;
      start_frame(w, len, d);
      expect_frame(w, len, d, lw, $urandom_range(60, 1), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/joybus_tx_engine.md
Name: joybus_tx_engine

Overview:
- Parameterised Joybus (N64 controller-side) response transmitter.
- Serialises a variable-length byte payload, MSB first, into Joybus level encoding, then appends the controller stop bit and hands the line back to the receive path.
- Successor to the fixed 24/32-bit controller transmitter:
  - programmable level width and maximum payload size;
  - start/busy/done handshake;
  - open-drain drive output;
  - length error reporting;
  - clean abort on reset.
- Sits between the command decoder (supplies payload and length) and the bidirectional data pad (open-drain pull-low).

Parameters:
LEVEL_WIDTH, 2, sample_clk cycles per line level (>=1); bit = 4 levels = 4*LEVEL_WIDTH cycles
MAX_BYTES, 4, maximum payload bytes; tx_data width = 8*MAX_BYTES
LEN_W, 3, width of tx_len; must hold MAX_BYTES+1

Ports:
sample_clk  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  request transmit; sampled only in IDLE
tx_len  input  LEN_W  payload length in bytes, sampled with start
tx_data  input  8*MAX_BYTES  payload, left-aligned; bit [8*MAX_BYTES-1] sent first; sampled with start
drive_low  output  1  1 = pull Joybus line low, 0 = release (line pulled high externally)
busy  output  1  high while a frame is on the line
done  output  1  one-cycle pulse at frame end
rx_handoff  output  1  one-cycle pulse coincident with done; receive path may take the line
len_err  output  1  one-cycle pulse when start is rejected for tx_len > MAX_BYTES

Behaviour:
- Reset (reset=0 at a rising edge):
  - next cycle: drive_low=0, busy=0, done=0, rx_handoff=0, len_err=0;
  - state=IDLE; all counters cleared.
  - Mid-frame reset aborts immediately; the line is released at the next edge with no stop bit.
- Level encoding as drive_low sequence, each level held LEVEL_WIDTH cycles:
  - logical 0 = 1,1,1,0 (L,L,L,H);
  - logical 1 = 1,0,0,0 (L,H,H,H);
  - stop = 1,1,0,0 (L,L,H,H).
- States: IDLE, SEND, STOP, FINISH.
- IDLE:
  - Outputs low.
  - start=1 and tx_len<=MAX_BYTES:
    - latch tx_data into the shift register;
    - nbits = 8*tx_len;
    - busy=1 and drive_low=1 at the same edge (first level, always L);
    - go to SEND, or to STOP if tx_len=0.
  - start=1 and tx_len>MAX_BYTES: pulse len_err one cycle; stay IDLE; line untouched.
- SEND:
  - Level counter runs 0..LEVEL_WIDTH-1; phase counter runs 0..3; bit counter runs 0..nbits-1.
  - drive_low follows the encoding of the current MSB for the current phase.
  - After phase 3 of the last bit, enter STOP with drive_low=1 on the same edge. There is no idle gap between bits or before the stop bit.
- STOP: emits the stop pattern, then goes to FINISH.
- FINISH (1 cycle): drive_low=0, busy=0, done=1, rx_handoff=1; return to IDLE.
- Timing:
  - busy is high for exactly (32*tx_len+4)*LEVEL_WIDTH cycles.
  - drive_low changes only on level boundaries.
- start while busy: ignored, with no effect on the frame in progress.
- start in the FINISH cycle: ignored. A new start is accepted on the first IDLE cycle.
- tx_data and tx_len changes after acceptance: no effect.
- Counter widths are sized from the parameters; there is no wrap-around inside a frame.

Test Plan:
- LEVEL_WIDTH=2, MAX_BYTES=4, tx_len=3, tx_data=0x05000000 (INFO):
  - busy for 200 cycles;
  - bits 0000_0101 then 16 zeros, checked level-by-level;
  - stop pattern 1,1,0,0 (2 cycles each);
  - done and rx_handoff high together for 1 cycle.
- tx_len=4, tx_data=0x00000000 (STATUS): 32 patterns of 1,1,1,1,1,1,0,0; busy 264 cycles.
- tx_len=0: drive_low=1,1,1,1,0,0,0,0 then done; busy 8 cycles.
- tx_len=5 with MAX_BYTES=4: single len_err pulse; busy, drive_low and done stay 0.
- Re-issue start mid-frame: ignored, and the frame matches the golden trace.
  - Then assert reset=0 at cycle 40 of a frame: next edge drive_low=0 and busy=0, with no done.
  - After reset release, a new start with tx_len=1, tx_data=0x80.. transmits L,H,H,H followed by seven 0 patterns.
- LEVEL_WIDTH=4 instance, tx_len=1, tx_data=0xA5: each level lasts 4 cycles; busy 144 cycles; bit order 1,0,1,0,0,1,0,1.
